rv32i_core: RTL and testbench

//  Single-cycle RV32I (user integer subset) processor with on-chip instruction/data memories.

---
 rtl/rv32i_pkg.sv | 91 +++++++++
 rtl/rv32i_regfile.sv | 39 +++
 rtl/rv32i_core.sv | 231 +++++++++++++++++++++++
 tb/tb_rv32i_core.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, MMIO addresses, control enums and
// small decode helpers (immediate generation, ALU operation selection).
// No ports; imported by rv32i_regfile and rv32i_core.
package rv32i_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // Load/store width funct3
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // OP / OP-IMM funct3
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // Memory-mapped I/O registers
  localparam logic [31:0] MMIO_LEDS_ADDR = 32'h8000_0000;
  localparam logic [31:0] MMIO_TX_ADDR   = 32'h8000_0004;
  localparam logic [31:0] MMIO_BTN_ADDR  = 32'h8000_0008;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic { OP1_RS1, OP1_PC } op1_sel_e;
  typedef enum logic { OP2_RS2, OP2_IMM } op2_sel_e;
  typedef enum logic [1:0] { WB_ALU, WB_MEM, WB_PC4, WB_IMM } wb_sel_e;
  typedef enum logic [2:0] { IMM_I, IMM_S, IMM_B, IMM_U, IMM_J } imm_type_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_type_e t);
    logic [31:0] v;
    case (t)
      IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   v = {ins[31:12], 12'b0};
      IMM_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: v = {{20{ins[31]}}, ins[31:20]};
    endcase
    return v;
  endfunction

  // alt is instr[30]; SUB only exists in the register form (in OP-IMM that bit is immediate).
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32 x 32-bit integer register file, x0 hardwired to zero.
// Ports: clk, rst_n (async, clears all registers), two combinational read ports
// (rs1/rs2), one write port (we, rd_addr, rd_data) committed on rising clk.
module rv32i_regfile
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[rd_addr] = rd_data;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rs1_data = regs_q[rs1_addr];
  assign rs2_data = regs_q[rs2_addr];

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with on-chip instruction and data memories; one instruction
// retires per rising clk. Ports: clk, rst_n (async active-low), btn[1:0] in, leds[5:0]
// and tx_word[31:0] out. Define CORE_MMIO_EN to map addresses >= 0x8000_0000 to I/O.
module rv32i_core
  import rv32i_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 4096,
  parameter int unsigned DMEM_WORDS = 4096,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  btn,
  output logic [5:0]  leds,
  output logic [31:0] tx_word
);

  localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
  localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

  // Instruction memory is read-only to the core; it is loaded externally.
  logic [31:0] imem   [IMEM_WORDS];
  logic [31:0] dmem_q [DMEM_WORDS];

  logic [31:0] pc_q, pc_d, pc_plus4, br_target;
  logic [31:0] instr, imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [4:0]  shamt;
  logic [31:0] mem_rdata, io_rdata, load_data, store_wdata, rf_wdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [3:0]  store_be;
  logic [DMEM_AW-1:0] dmem_idx;
  logic        is_io, dmem_we, br_taken;
  logic [5:0]  leds_q, leds_d;
  logic [31:0] tx_word_q, tx_word_d;

  logic        rf_we, is_branch, is_jal, is_jalr, is_store, csr_zero;
  alu_op_e     alu_op;
  op1_sel_e    op1_sel;
  op2_sel_e    op2_sel;
  wb_sel_e     wb_sel;
  imm_type_e   imm_type;

  // Fetch
  assign instr    = imem[pc_q[IMEM_AW+1:2]];
  assign opcode   = instr[6:0];
  assign rd_addr  = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  // Decode
  always_comb begin
    rf_we     = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_store  = 1'b0;
    csr_zero  = 1'b0;
    alu_op    = ALU_ADD;
    op1_sel   = OP1_RS1;
    op2_sel   = OP2_IMM;
    wb_sel    = WB_ALU;
    imm_type  = IMM_I;
    case (opcode)
      OPC_LUI:    begin rf_we = 1'b1; wb_sel = WB_IMM; imm_type = IMM_U; end
      OPC_AUIPC:  begin rf_we = 1'b1; op1_sel = OP1_PC; imm_type = IMM_U; end
      OPC_JAL:    begin rf_we = 1'b1; wb_sel = WB_PC4; imm_type = IMM_J; is_jal = 1'b1; end
      OPC_JALR:   begin rf_we = 1'b1; wb_sel = WB_PC4; is_jalr = 1'b1; end
      OPC_BRANCH: begin imm_type = IMM_B; is_branch = 1'b1; end
      OPC_LOAD:   begin rf_we = 1'b1; wb_sel = WB_MEM; end
      OPC_STORE:  begin imm_type = IMM_S; is_store = 1'b1; end
      OPC_OPIMM:  begin rf_we = 1'b1; alu_op = alu_decode(funct3, instr[30], 1'b0); end
      OPC_OP: begin
        rf_we   = 1'b1;
        op2_sel = OP2_RS2;
        alu_op  = alu_decode(funct3, instr[30], 1'b1);
      end
      // ECALL/EBREAK (funct3 == 0) are NOPs; CSR forms only clear rd.
      OPC_SYSTEM: begin rf_we = (funct3 != 3'd0); csr_zero = 1'b1; end
      default: ;  // FENCE and unknown opcodes fall through as NOPs
    endcase
  end

  assign imm = gen_imm(instr, imm_type);

  rv32i_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (rf_we),
    .rd_addr  (rd_addr),
    .rd_data  (rf_wdata)
  );

  // ALU; also produces load/store addresses and the JALR target.
  always_comb begin
    alu_a   = (op1_sel == OP1_PC)  ? pc_q : rs1_data;
    alu_b   = (op2_sel == OP2_IMM) ? imm  : rs2_data;
    shamt   = alu_b[4:0];
    alu_res = alu_a + alu_b;
    case (alu_op)
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << shamt;
      ALU_SLT:  alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SRL:  alu_res = alu_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      default:  alu_res = alu_a + alu_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_data == rs2_data);
      F3_BNE:  br_taken = (rs1_data != rs2_data);
      F3_BLT:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: br_taken = (rs1_data <  rs2_data);
      F3_BGEU: br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_q + imm;

  always_comb begin
    pc_d = pc_plus4;
    if (is_jal || (is_branch && br_taken)) pc_d = br_target;
    else if (is_jalr)                      pc_d = {alu_res[31:1], 1'b0};
  end

  // Data memory: upper address bits are ignored, so the array aliases across the space.
  assign dmem_idx = alu_res[DMEM_AW+1:2];
  assign dmem_we  = is_store && !is_io;

  always_comb begin
    store_wdata = rs2_data;
    store_be    = 4'b1111;
    case (funct3)
      F3_B: begin store_wdata = {4{rs2_data[7:0]}};  store_be = 4'b0001 << alu_res[1:0]; end
      F3_H: begin store_wdata = {2{rs2_data[15:0]}}; store_be = alu_res[1] ? 4'b1100 : 4'b0011; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (dmem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b]) dmem_q[dmem_idx][8*b +: 8] <= store_wdata[8*b +: 8];
      end
    end
  end

`ifdef CORE_MMIO_EN
  assign is_io    = alu_res[31];
  assign io_rdata = (alu_res == MMIO_BTN_ADDR) ? {30'b0, btn} : 32'b0;

  always_comb begin
    leds_d    = leds_q;
    tx_word_d = tx_word_q;
    if (is_store && is_io) begin
      if (alu_res == MMIO_LEDS_ADDR) leds_d    = store_wdata[5:0];
      if (alu_res == MMIO_TX_ADDR)   tx_word_d = store_wdata;
    end
  end
`else
  logic unused_btn;
  assign unused_btn = ^btn;
  assign is_io      = 1'b0;
  assign io_rdata   = 32'b0;
  assign leds_d     = 6'b0;
  assign tx_word_d  = 32'b0;
`endif

  // Loads: misaligned halves/words are aligned down by lane selection on the word.
  assign mem_rdata = is_io ? io_rdata : dmem_q[dmem_idx];
  assign lane_byte = mem_rdata[{alu_res[1:0], 3'b000} +: 8];
  assign lane_half = alu_res[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_data = mem_rdata;
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_BU:   load_data = {24'b0, lane_byte};
      F3_HU:   load_data = {16'b0, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    rf_wdata = alu_res;
    case (wb_sel)
      WB_MEM:  rf_wdata = load_data;
      WB_PC4:  rf_wdata = pc_plus4;
      WB_IMM:  rf_wdata = imm;
      default: rf_wdata = alu_res;
    endcase
    if (csr_zero) rf_wdata = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      leds_q    <= '0;
      tx_word_q <= '0;
    end else begin
      pc_q      <= pc_d;
      leds_q    <= leds_d;
      tx_word_q <= tx_word_d;
    end
  end

  assign leds    = leds_q;
  assign tx_word = tx_word_q;

endmodule

// File: tb/tb_rv32i_core.sv
module tb_rv32i_core;

`ifdef CORE_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    bit          chk;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  btn = 2'b10;
  logic [5:0]  leds;
  logic [31:0] tx_word;

  int   checks = 0;
  int   errors = 0;
  int   wb_seen = 0;
  bit   mon_en = 1'b0;
  vec_t prog[$];
  exp_t exp_q[$];
  exp_t mon_e;

  rv32i_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .leds    (leds),
    .tx_word (tx_word)
  );

  always #5 clk = ~clk;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input int opc, input int rd, input int f3,
                                        input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input int f3, input int rs1, input int rs2, input int imm);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int off);
    logic [12:0] v;
    v = 13'(off);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input int opc, input int rd, input int imm20);
    return {20'(imm20), 5'(rd), 7'(opc)};
  endfunction
  function automatic logic [31:0] enc_j(input int rd, input int off);
    logic [20:0] v;
    v = 21'(off);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(7'h13, rd, 0, rs1, imm);
  endfunction
  function automatic logic [31:0] load(input int f3, input int rd, input int rs1, input int imm);
    return enc_i(7'h03, rd, f3, rs1, imm);
  endfunction

  // ---------------- program table builders ----------------
  task automatic put_w(input logic [31:0] ins, input int rd, input logic [31:0] exp);
    vec_t v;
    v.instr = ins; v.chk = 1'b1; v.rd = 5'(rd); v.exp = exp;
    prog.push_back(v);
  endtask
  task automatic put_n(input logic [31:0] ins);
    vec_t v;
    v.instr = ins; v.chk = 1'b0; v.rd = 5'd0; v.exp = 32'h0;
    prog.push_back(v);
  endtask
  task automatic pad_to(input int addr);
    while (prog.size() * 4 < addr) put_n(addi(0, 0, 0));
  endtask
  function automatic logic [31:0] cur_pc();
    return 32'(prog.size() * 4);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Load the table into imem, queue the expected writebacks, run until the
  // program's final self-loop address is reached.
  task automatic run_prog(input string name);
    logic [31:0] pass_pc;
    int c;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) dut.imem[12'(i)] = addi(0, 0, 0);
    for (int i = 0; i < prog.size(); i++) begin
      dut.imem[12'(i)] = prog[i].instr;
      if (prog[i].chk) exp_q.push_back('{rd: prog[i].rd, val: prog[i].exp});
    end
    pass_pc = 32'((prog.size() - 1) * 4);
    mon_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    c = 0;
    while (dut.pc_q !== pass_pc && c < 16000) begin
      @(negedge clk);
      c++;
    end
    check({name, " reached pass pc"}, dut.pc_q, pass_pc);
    check({name, " writebacks left"}, 32'(exp_q.size()), 32'd0);
    prog.delete();
  endtask

  // Scoreboard: every architectural register write is compared in order.
  always @(negedge clk) begin
    if (mon_en && rst_n && dut.rf_we && dut.rd_addr != 5'd0) begin
      checks++;
      wb_seen++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb#%0d unexpected: got x%0d=%h at pc %h, expected no write",
                 wb_seen, dut.rd_addr, dut.rf_wdata, dut.pc_q);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.rd !== dut.rd_addr || mon_e.val !== dut.rf_wdata) begin
          errors++;
          $display("FAIL wb#%0d at pc %h: got x%0d=%h, expected x%0d=%h",
                   wb_seen, dut.pc_q, dut.rd_addr, dut.rf_wdata, mon_e.rd, mon_e.val);
        end
      end
    end
  end

  initial begin
    // ---------------- reset state ----------------
    #1;
    check("reset pc", dut.pc_q, 32'h0);
    check("reset leds", 32'(leds), 32'h0);
    check("reset tx_word", tx_word, 32'h0);
    check("reset x5", dut.u_rf.regs_q[5], 32'h0);

    // ---------------- ALU / x0 / SYSTEM ----------------
    put_w(addi(1, 0, -1), 1, 32'hFFFF_FFFF);
    put_w(enc_i(7'h13, 2, 5, 1, 28), 2, 32'h0000_000F);           // srli
    put_w(enc_i(7'h13, 3, 5, 1, 12'h400 | 28), 3, 32'hFFFF_FFFF); // srai
    put_n(addi(0, 0, 7));
    put_w(enc_r(0, 0, 0, 0, 4), 4, 32'h0);                        // add x4,x0,x0
    put_w(addi(5, 0, 5), 5, 32'h5);
    put_w(enc_r(7'h20, 1, 5, 0, 6), 6, 32'h6);                    // sub
    put_w(enc_r(0, 5, 1, 2, 7), 7, 32'h1);                        // slt
    put_w(enc_r(0, 5, 1, 3, 8), 8, 32'h0);                        // sltu
    put_w(enc_i(7'h13, 9, 4, 5, -1), 9, 32'hFFFF_FFFA);           // xori
    put_w(enc_i(7'h13, 10, 1, 5, 31), 10, 32'h8000_0000);         // slli
    put_w(enc_r(0, 5, 5, 1, 11), 11, 32'h0000_00A0);              // sll
    put_w(enc_r(0, 10, 5, 6, 12), 12, 32'h8000_0005);             // or
    put_w(enc_r(0, 5, 1, 7, 13), 13, 32'h5);                      // and
    put_w(enc_i(7'h13, 14, 7, 1, 12'h0F0), 14, 32'h0000_00F0);    // andi
    put_w(enc_r(7'h20, 5, 10, 5, 15), 15, 32'hFC00_0000);         // sra
    put_w(enc_r(0, 5, 10, 5, 16), 16, 32'h0400_0000);             // srl
    put_w(enc_i(7'h13, 17, 2, 1, 0), 17, 32'h1);                  // slti
    put_w(enc_i(7'h13, 18, 3, 5, -1), 18, 32'h1);                 // sltiu
    put_w(enc_u(7'h17, 19, 1), 19, cur_pc() + 32'h1000);          // auipc
    put_w(enc_u(7'h37, 20, 20'hABCDE), 20, 32'hABCD_E000);        // lui
    put_w(addi(21, 0, 9), 21, 32'h9);
    put_w(enc_i(7'h73, 21, 2, 0, 12'h300), 21, 32'h0);            // csrrs
    put_n(32'h0000_0073);                                         // ecall
    put_n(32'h0010_0073);                                         // ebreak
    put_n(32'h0FF0_000F);                                         // fence
    put_n(32'hFFFF_FFFF);                                         // unknown opcode
    put_w(enc_r(0, 20, 21, 0, 22), 22, 32'hABCD_E000);
    put_n(enc_j(0, 0));
    run_prog("alu");
    check("x0 after addi x0", dut.u_rf.regs_q[0], 32'h0);

    // ---------------- loads / stores / MMIO ----------------
    put_w(enc_u(7'h37, 1, 20'h12345), 1, 32'h1234_5000);
    put_w(addi(1, 1, 12'h678), 1, 32'h1234_5678);
    put_n(enc_s(2, 0, 1, 8));                                     // sw x1,8(x0)
    put_w(load(0, 2, 0, 9), 2, 32'h0000_0056);                    // lb
    put_w(load(5, 3, 0, 10), 3, 32'h0000_1234);                   // lhu
    put_w(load(4, 4, 0, 11), 4, 32'h0000_0012);                   // lbu
    put_w(addi(5, 0, -2), 5, 32'hFFFF_FFFE);
    put_n(enc_s(2, 0, 0, 12));                                    // sw x0,12
    put_n(enc_s(1, 0, 5, 14));                                    // sh x5,14
    put_w(load(2, 6, 0, 12), 6, 32'hFFFE_0000);
    put_w(load(1, 7, 0, 14), 7, 32'hFFFF_FFFE);                   // lh
    put_w(load(5, 8, 0, 15), 8, 32'h0000_FFFE);                   // lhu misaligned
    put_w(load(0, 9, 0, 14), 9, 32'hFFFF_FFFE);                   // lb
    put_n(enc_s(0, 0, 1, 13));                                    // sb x1,13
    put_w(load(2, 10, 0, 12), 10, 32'hFFFE_7800);
    put_w(load(2, 11, 0, 9), 11, 32'h1234_5678);                  // lw misaligned
    put_w(enc_u(7'h37, 13, 4), 13, 32'h0000_4000);
    put_w(load(2, 12, 13, 8), 12, 32'h1234_5678);                 // aliased upper bits
    put_w(enc_u(7'h37, 14, 20'h80000), 14, 32'h8000_0000);
    put_w(addi(15, 0, 12'h02A), 15, 32'h0000_002A);
    put_n(enc_s(2, 14, 15, 0));
    put_w(enc_u(7'h37, 16, 20'hDEADC), 16, 32'hDEAD_C000);
    put_w(addi(16, 16, -273), 16, 32'hDEAD_BEEF);
    put_n(enc_s(2, 14, 16, 4));
    put_w(load(2, 17, 14, 8), 17, MMIO ? 32'h0000_0002 : 32'h1234_5678);
    put_w(load(2, 18, 14, 12), 18, MMIO ? 32'h0000_0000 : 32'hFFFE_7800);
    put_n(enc_j(0, 0));
    run_prog("mem");
    check("dmem[2]", dut.dmem_q[2], 32'h1234_5678);
    check("dmem[3]", dut.dmem_q[3], 32'hFFFE_7800);
    check("leds after mem", 32'(leds), MMIO ? 32'h2A : 32'h0);
    check("tx_word after mem", tx_word, MMIO ? 32'hDEAD_BEEF : 32'h0);

    // ---------------- branches / jumps ----------------
    put_w(addi(1, 0, 5), 1, 32'h5);
    put_w(addi(2, 0, -1), 2, 32'hFFFF_FFFF);
    put_n(enc_b(4, 2, 1, 8));                                     // blt taken
    put_n(addi(3, 0, 1));
    put_n(enc_b(6, 2, 1, 8));                                     // bltu not taken
    put_w(addi(4, 0, 2), 4, 32'h2);
    put_n(enc_b(0, 1, 1, 8));                                     // beq taken
    put_n(addi(3, 0, 3));
    put_n(enc_b(1, 1, 1, 8));                                     // bne not taken
    put_w(addi(6, 0, 6), 6, 32'h6);
    put_n(enc_b(5, 1, 2, 8));                                     // bge taken
    put_n(addi(3, 0, 4));
    put_n(enc_b(7, 1, 2, 8));                                     // bgeu not taken
    put_w(addi(7, 0, 7), 7, 32'h7);
    pad_to(32'h40);
    put_w(enc_j(5, 16), 5, 32'h44);                               // jal x5,+16
    put_n(addi(8, 0, 1));
    put_n(addi(8, 0, 2));
    put_n(addi(8, 0, 3));
    put_w(addi(9, 0, 12'h061), 9, 32'h61);                        // at 0x50
    put_w(enc_i(7'h67, 10, 0, 9, 0), 10, 32'h58);                 // jalr -> 0x60
    put_n(addi(8, 0, 4));
    put_n(addi(8, 0, 5));
    put_n(enc_j(0, 0));                                           // 0x60
    run_prog("branch");

    // ---------------- asynchronous reset mid-program ----------------
    mon_en = 1'b0;
    rst_n  = 1'b0;
    put_n(enc_u(7'h37, 14, 20'h80000));
    put_n(addi(15, 0, 12'h02A));
    put_n(enc_s(2, 14, 15, 0));
    put_n(enc_u(7'h37, 16, 20'hDEADC));
    put_n(addi(16, 16, -273));
    put_n(enc_s(2, 14, 16, 4));
    put_n(addi(1, 1, 1));
    put_n(enc_j(0, -4));
    for (int i = 0; i < 64; i++) dut.imem[12'(i)] = addi(0, 0, 0);
    for (int i = 0; i < prog.size(); i++) dut.imem[12'(i)] = prog[i].instr;
    prog.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("leds before reset", 32'(leds), MMIO ? 32'h2A : 32'h0);
    check("tx_word before reset", tx_word, MMIO ? 32'hDEAD_BEEF : 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset pc", dut.pc_q, 32'h0);
    check("async reset leds", 32'(leds), 32'h0);
    check("async reset tx_word", tx_word, 32'h0);
    check("async reset x1", dut.u_rf.regs_q[1], 32'h0);
    check("dmem kept over reset", dut.dmem_q[2], 32'h1234_5678);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("restart pc", dut.pc_q, 32'hC);
    check("restart x14", dut.u_rf.regs_q[14], 32'h8000_0000);
    check("restart x15", dut.u_rf.regs_q[15], 32'h0000_002A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
